// File: rtl/conv_engine.sv
// Multi-filter 1-D convolution engine: streamed tap/sample load,
// one MAC per cycle, valid/ready result port.
module conv_engine #(
  parameter int NUM_FILTERS = 3,
  parameter int K           = 4,
  parameter int N           = 16,
  parameter int DW          = 8,
  parameter int STRIDE      = 1,
  parameter int ACC_W       = 2*DW+$clog2(K)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    keep_filters,
  input  logic                    relu_en,
  output logic                    busy,
  output logic                    done,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [DW-1:0]           ld_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic [$clog2(NUM_FILTERS>1 ? NUM_FILTERS : 2)-1:0] out_filter,
  output logic [$clog2(((N-K)/STRIDE+1)>1 ? ((N-K)/STRIDE+1) : 2)-1:0] out_pos
);

  localparam int M  = (N-K)/STRIDE+1;
  localparam int NT = NUM_FILTERS*K;
  localparam int FW = $clog2(NUM_FILTERS>1 ? NUM_FILTERS : 2);
  localparam int PW = $clog2(M>1 ? M : 2);
  localparam int KW = $clog2(K>1 ? K : 2);
  localparam int IW = $clog2(N>1 ? N : 2);
  localparam int TW = $clog2(NT>1 ? NT : 2);
  localparam int CW = $clog2((NT>N ? NT : N)+1);

  typedef enum logic [2:0] {
    IDLE, LOAD_F, LOAD_I, MAC, OUT, DONE
  } state_t;

  state_t state;

  logic signed [DW-1:0]    filt [NT];
  logic signed [DW-1:0]    img  [N];
  logic [CW-1:0]           lcnt;
  logic [KW-1:0]           t;
  logic [FW-1:0]           f;
  logic [PW-1:0]           p;
  logic [IW-1:0]           base;
  logic                    relu;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [2*DW-1:0]  prod;
  logic [IW-1:0]           img_idx;
  logic [TW-1:0]           tap_idx;
  logic                    beat;

  assign ld_ready = (state == LOAD_F) || (state == LOAD_I);
  assign busy     = (state != IDLE);
  assign beat     = ld_valid && ld_ready;

  always_comb begin
    img_idx  = base + IW'(t);
    tap_idx  = TW'(f) * TW'(K) + TW'(t);
    prod     = img[img_idx] * filt[tap_idx];
    acc_next = acc + ACC_W'(prod);
  end

  // Buffers carry no reset so stored taps survive a reset for reuse.
  always_ff @(posedge clk) begin
    if (beat) begin
      if (state == LOAD_F) filt[lcnt[TW-1:0]] <= ld_data;
      else                 img[lcnt[IW-1:0]]  <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_filter <= '0;
      out_pos    <= '0;
      lcnt       <= '0;
      t          <= '0;
      f          <= '0;
      p          <= '0;
      base       <= '0;
      relu       <= 1'b0;
      acc        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            relu  <= relu_en;
            lcnt  <= '0;
            state <= keep_filters ? LOAD_I : LOAD_F;
          end
        end
        LOAD_F: begin
          if (beat) begin
            if (lcnt == CW'(NT-1)) begin
              lcnt  <= '0;
              state <= LOAD_I;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
        end
        LOAD_I: begin
          if (beat) begin
            if (lcnt == CW'(N-1)) begin
              lcnt  <= '0;
              acc   <= '0;
              t     <= '0;
              f     <= '0;
              p     <= '0;
              base  <= '0;
              state <= MAC;
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
        end
        MAC: begin
          if (t == KW'(K-1)) begin
            out_data   <= (relu && acc_next[ACC_W-1]) ? '0 : acc_next;
            out_filter <= f;
            out_pos    <= p;
            out_valid  <= 1'b1;
            state      <= OUT;
          end else begin
            acc <= acc_next;
            t   <= t + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            t         <= '0;
            if (f != FW'(NUM_FILTERS-1)) begin
              f     <= f + 1'b1;
              state <= MAC;
            end else if (p != PW'(M-1)) begin
              f     <= '0;
              p     <= p + 1'b1;
              base  <= base + IW'(STRIDE);
              state <= MAC;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine: default instance plus a STRIDE=2
// instance sharing the load stream.
module tb_conv_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, keep_filters, relu_en;
  logic              ld_valid, out_ready;
  logic [7:0]        ld_data;
  logic              busy, done, ld_ready, out_valid;
  logic signed [17:0] out_data;
  logic [1:0]        out_filter;
  logic [3:0]        out_pos;
  logic              busy2, done2, ld_ready2, out_valid2;
  logic signed [17:0] out_data2;
  logic [1:0]        out_filter2;
  logic [2:0]        out_pos2;

  conv_engine u_dut (
    .clk(clk), .rst(rst), .start(start),
    .keep_filters(keep_filters), .relu_en(relu_en),
    .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_filter(out_filter), .out_pos(out_pos)
  );

  conv_engine #(.STRIDE(2)) u_s2 (
    .clk(clk), .rst(rst), .start(start),
    .keep_filters(keep_filters), .relu_en(relu_en),
    .busy(busy2), .done(done2),
    .ld_valid(ld_valid), .ld_ready(ld_ready2), .ld_data(ld_data),
    .out_valid(out_valid2), .out_ready(1'b1),
    .out_data(out_data2), .out_filter(out_filter2), .out_pos(out_pos2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd[$], rf[$], rp[$], rc[$];
  int sd[$], sf[$], sp[$];
  int nbeats, ndone;
  int taps[12] = '{1,1,1,1, 1,0,0,-1, 2,0,0,0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        rd.push_back(int'(out_data));
        rf.push_back(int'(out_filter));
        rp.push_back(int'(out_pos));
        rc.push_back(cyc);
      end
      if (out_valid2) begin
        sd.push_back(int'(out_data2));
        sf.push_back(int'(out_filter2));
        sp.push_back(int'(out_pos2));
      end
      if (ld_valid && ld_ready) nbeats++;
      if (done) ndone++;
    end
  end

  // Hand-derived closed forms; mode 0 image 0..15, 1 same with relu,
  // 2 image 15..0, 3 image 0..15 at stride 2.
  function automatic int expv(int mode, int fi, int pi);
    case (mode)
      0: return fi == 0 ? 4*pi+6  : fi == 1 ? -3 : 2*pi;
      1: return fi == 0 ? 4*pi+6  : fi == 1 ? 0  : 2*pi;
      2: return fi == 0 ? 54-4*pi : fi == 1 ? 3  : 30-2*pi;
      default: return fi == 0 ? 8*pi+6 : fi == 1 ? -3 : 4*pi;
    endcase
  endfunction

  task automatic clear_mon();
    rd.delete(); rf.delete(); rp.delete(); rc.delete();
    sd.delete(); sf.delete(); sp.delete();
    nbeats = 0;
    ndone  = 0;
  endtask

  task automatic start_run(input logic keep, input logic relu);
    @(posedge clk); #1;
    start = 1'b1; keep_filters = keep; relu_en = relu;
    @(posedge clk); #1;
    start = 1'b0; keep_filters = 1'b0; relu_en = 1'b0;
  endtask

  task automatic load(input logic filters, input logic down, input int extra);
    if (filters) begin
      for (int i = 0; i < 12; i++) begin
        ld_valid = 1'b1; ld_data = 8'(taps[i]);
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 16 + extra; i++) begin
      ld_valid = 1'b1; ld_data = down ? 8'(15-i) : 8'(i);
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_timeout got no done within %0d cycles", name, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; keep_filters = 0; relu_en = 0;
    ld_valid = 0; ld_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ld_ready, out_valid} !== 4'b0 || out_data !== 18'sd0 ||
        out_filter !== 2'd0 || out_pos !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs got b%0b d%0b r%0b v%0b %0d %0d %0d want zeros",
               busy, done, ld_ready, out_valid, out_data, out_filter, out_pos);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int n = 0;
    int bad = 0;
    clear_mon();
    start_run(1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_busy got b%0b r%0b want 1 1", busy, ld_ready);
    end
    load(1'b1, 1'b0, 0);
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL first_latency got %0d want 4", n);
    end
    wait_done("basic");
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_done got b%0b d%0b want 0 0", busy, done);
    end
    checks++;
    if (rd.size() !== 39 || ndone !== 1) begin
      errors++;
      $display("FAIL basic_count got %0d res %0d done want 39 1", rd.size(), ndone);
    end
    for (int i = 0; i < rd.size() && i < 39; i++) begin
      checks++;
      if (rd[i] !== expv(0, i%3, i/3) || rf[i] !== i%3 || rp[i] !== i/3) begin
        errors++;
        $display("FAIL basic_res%0d got %0d f%0d p%0d want %0d f%0d p%0d",
                 i, rd[i], rf[i], rp[i], expv(0, i%3, i/3), i%3, i/3);
      end
    end
    for (int i = 1; i < rc.size(); i++)
      if (rc[i] - rc[i-1] != 5) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL throughput got %0d gaps not 5 want 0", bad);
    end
    checks++;
    if (sd.size() !== 21) begin
      errors++;
      $display("FAIL s2_count got %0d want 21", sd.size());
    end
  endtask

  task automatic test_relu();
    clear_mon();
    start_run(1'b0, 1'b1);
    load(1'b1, 1'b0, 0);
    wait_done("relu");
    checks++;
    if (rd.size() !== 39 || ndone !== 1) begin
      errors++;
      $display("FAIL relu_count got %0d res %0d done want 39 1", rd.size(), ndone);
    end
    for (int i = 0; i < rd.size() && i < 39; i++) begin
      checks++;
      if (rd[i] !== expv(1, i%3, i/3) || rf[i] !== i%3 || rp[i] !== i/3) begin
        errors++;
        $display("FAIL relu_res%0d got %0d f%0d p%0d want %0d",
                 i, rd[i], rf[i], rp[i], expv(1, i%3, i/3));
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    clear_mon();
    start_run(1'b0, 1'b0);
    load(1'b1, 1'b0, 0);
    while (!(out_valid && out_pos == 4'd3 && out_filter == 2'd1) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== -18'sd3 ||
          out_filter !== 2'd1 || out_pos !== 4'd3) begin
        errors++;
        $display("FAIL stall_hold%0d got v%0b %0d f%0d p%0d want 1 -3 f1 p3",
                 i, out_valid, out_data, out_filter, out_pos);
      end
    end
    out_ready = 1'b1;
    wait_done("stall");
    checks++;
    if (rd.size() !== 39) begin
      errors++;
      $display("FAIL stall_count got %0d want 39", rd.size());
    end
    for (int i = 0; i < rd.size() && i < 39; i++) begin
      checks++;
      if (rd[i] !== expv(0, i%3, i/3) || rf[i] !== i%3 || rp[i] !== i/3) begin
        errors++;
        $display("FAIL stall_res%0d got %0d f%0d p%0d want %0d",
                 i, rd[i], rf[i], rp[i], expv(0, i%3, i/3));
      end
    end
  endtask

  task automatic test_keep_filters();
    clear_mon();
    start_run(1'b1, 1'b0);
    load(1'b0, 1'b1, 4);
    checks++;
    if (nbeats !== 16 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL keep_beats got %0d r%0b want 16 0", nbeats, ld_ready);
    end
    wait_done("keep");
    checks++;
    if (rd.size() !== 39) begin
      errors++;
      $display("FAIL keep_count got %0d want 39", rd.size());
    end
    for (int i = 0; i < rd.size() && i < 39; i++) begin
      checks++;
      if (rd[i] !== expv(2, i%3, i/3) || rf[i] !== i%3 || rp[i] !== i/3) begin
        errors++;
        $display("FAIL keep_res%0d got %0d f%0d p%0d want %0d",
                 i, rd[i], rf[i], rp[i], expv(2, i%3, i/3));
      end
    end
  endtask

  task automatic test_stride();
    clear_mon();
    start_run(1'b0, 1'b0);
    load(1'b1, 1'b0, 0);
    wait_done("stride");
    checks++;
    if (sd.size() !== 21) begin
      errors++;
      $display("FAIL stride_count got %0d want 21", sd.size());
    end
    for (int i = 0; i < sd.size() && i < 21; i++) begin
      checks++;
      if (sd[i] !== expv(3, i%3, i/3) || sf[i] !== i%3 || sp[i] !== i/3) begin
        errors++;
        $display("FAIL stride_res%0d got %0d f%0d p%0d want %0d f%0d p%0d",
                 i, sd[i], sf[i], sp[i], expv(3, i%3, i/3), i%3, i/3);
      end
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    clear_mon();
    start_run(1'b0, 1'b0);
    load(1'b1, 1'b0, 0);
    while (!(out_valid && out_pos == 4'd5) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, ld_ready, out_valid} !== 4'b0 || out_data !== 18'sd0 ||
        out_filter !== 2'd0 || out_pos !== 4'd0) begin
      errors++;
      $display("FAIL midrst_outputs got b%0b d%0b r%0b v%0b %0d %0d %0d want zeros",
               busy, done, ld_ready, out_valid, out_data, out_filter, out_pos);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    start_run(1'b0, 1'b0);
    load(1'b1, 1'b0, 0);
    wait_done("midrst");
    checks++;
    if (rd.size() !== 39 || ndone !== 1) begin
      errors++;
      $display("FAIL midrst_count got %0d res %0d done want 39 1", rd.size(), ndone);
    end
    for (int i = 0; i < rd.size() && i < 39; i++) begin
      checks++;
      if (rd[i] !== expv(0, i%3, i/3) || rf[i] !== i%3 || rp[i] !== i/3) begin
        errors++;
        $display("FAIL midrst_res%0d got %0d f%0d p%0d want %0d",
                 i, rd[i], rf[i], rp[i], expv(0, i%3, i/3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_backpressure();
    test_keep_filters();
    test_stride();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
